// File: rtl/verificador_senha_param_if.sv
// Handshake and status bundle between the keypad/serial front end and the
// password engine. The engine uses the slave view, the driver the master view.
//
// Handshake: a character moves from master to slave in a cycle where both
// char_valid and char_ready are high at the rising clock edge; the master
// holds char_data stable while char_valid is high and ready is low, and
// char_ready never depends combinationally on char_valid.
interface verificador_senha_param_if #(
    parameter int CHAR_W  = 8,
    parameter int MAX_LEN = 16,
    parameter int TENT_W  = 4
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);

    // Command and character inputs to the engine
    logic              start;
    logic              prog;
    logic              cancel;
    logic [LEN_W-1:0]  senha_len;
    logic [TENT_W-1:0] max_tentativas;
    logic              char_valid;
    logic [CHAR_W-1:0] char_data;

    // Engine results and debug visibility
    logic              char_ready;
    logic              acesso;
    logic              negado;
    logic              prog_ok;
    logic              bloqueado;
    logic              ocupado;
    logic [2:0]        db_estado;
    logic [LEN_W-1:0]  db_contagem;
    logic [TENT_W-1:0] db_tentativas;

    modport master (
        output start, prog, cancel, senha_len, max_tentativas, char_valid, char_data,
        input  char_ready, acesso, negado, prog_ok, bloqueado, ocupado,
               db_estado, db_contagem, db_tentativas
    );

    modport slave (
        input  start, prog, cancel, senha_len, max_tentativas, char_valid, char_data,
        output char_ready, acesso, negado, prog_ok, bloqueado, ocupado,
               db_estado, db_contagem, db_tentativas
    );
endinterface

// File: rtl/verificador_senha_param.sv
// Password engine: programs a password of up to MAX_LEN characters, checks
// typed characters against it on the fly, counts failed attempts and holds a
// timed lockout once the configured number of failures is reached.
module verificador_senha_param #(
    parameter int CHAR_W      = 8,
    parameter int MAX_LEN     = 16,
    parameter int TENT_W      = 4,
    parameter int LOCK_CYCLES = 1000
) (
    input logic clock,
    input logic reset,
    verificador_senha_param_if.slave bus
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int TIM_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PROGRAMA = 3'd1,
        VERIFICA = 3'd2,
        AVALIA   = 3'd3,
        BLOQUEIO = 3'd4
    } estado_t;

    estado_t           estado_q, estado_d;
    logic [LEN_W-1:0]  idx_q, idx_d;     // current character index
    logic [LEN_W-1:0]  len_q, len_d;     // committed password length
    logic [LEN_W-1:0]  plen_q, plen_d;   // length being programmed
    logic              err_q, err_d;     // sticky mismatch flag for this attempt
    logic [TENT_W-1:0] tent_q, tent_d;   // failed-attempt counter
    logic [TIM_W-1:0]  tim_q, tim_d;     // lockout countdown
    logic              prog_ok_q, prog_ok_d;

    logic [CHAR_W-1:0] pw_q [MAX_LEN];   // committed password
    logic [CHAR_W-1:0] sh_q [MAX_LEN];   // shadow filled during programming

    logic              xfer;
    logic              sh_we;
    logic              commit;
    logic [IDX_W-1:0]  widx;
    logic              mismatch;
    logic [LEN_W-1:0]  len_sat;
    logic [TENT_W-1:0] tent_inc;
    logic              lock_now;

    // Shared decode used by both the next-state and output logic
    assign xfer     = bus.char_valid & bus.char_ready;
    assign widx     = idx_q[IDX_W-1:0];
    assign mismatch = (bus.char_data != pw_q[widx]);
    assign len_sat  = ((bus.senha_len == '0) || (bus.senha_len > LEN_W'(MAX_LEN)))
                      ? LEN_W'(MAX_LEN) : bus.senha_len;
    assign tent_inc = (tent_q == '1) ? tent_q : tent_q + TENT_W'(1);
    assign lock_now = (bus.max_tentativas != '0) && (tent_inc >= bus.max_tentativas);

    // State and control registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q  <= IDLE;
            idx_q     <= '0;
            len_q     <= LEN_W'(MAX_LEN);
            plen_q    <= LEN_W'(MAX_LEN);
            err_q     <= 1'b0;
            tent_q    <= '0;
            tim_q     <= '0;
            prog_ok_q <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            idx_q     <= idx_d;
            len_q     <= len_d;
            plen_q    <= plen_d;
            err_q     <= err_d;
            tent_q    <= tent_d;
            tim_q     <= tim_d;
            prog_ok_q <= prog_ok_d;
        end
    end

    // Password and shadow storage; the final programming char bypasses the shadow
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                pw_q[i] <= '0;
                sh_q[i] <= '0;
            end
        end else begin
            if (sh_we) begin
                sh_q[widx] <= bus.char_data;
            end
            if (commit) begin
                for (int i = 0; i < MAX_LEN; i++) begin
                    pw_q[i] <= (IDX_W'(i) == widx) ? bus.char_data : sh_q[i];
                end
            end
        end
    end

    // Next-state logic
    always_comb begin
        estado_d  = estado_q;
        idx_d     = idx_q;
        len_d     = len_q;
        plen_d    = plen_q;
        err_d     = err_q;
        tent_d    = tent_q;
        tim_d     = tim_q;
        prog_ok_d = 1'b0;
        sh_we     = 1'b0;
        commit    = 1'b0;
        case (estado_q)
            IDLE: begin
                if (bus.start) begin
                    idx_d = '0;
                    err_d = 1'b0;
                    if (bus.prog) begin
                        plen_d   = len_sat;
                        estado_d = PROGRAMA;
                    end else begin
                        estado_d = VERIFICA;
                    end
                end
            end
            PROGRAMA: begin
                // cancel beats a simultaneous final char: nothing is committed
                if (bus.cancel) begin
                    estado_d = IDLE;
                end else if (xfer) begin
                    sh_we = 1'b1;
                    idx_d = idx_q + LEN_W'(1);
                    if (idx_q == plen_q - LEN_W'(1)) begin
                        commit    = 1'b1;
                        len_d     = plen_q;
                        prog_ok_d = 1'b1;
                        estado_d  = IDLE;
                    end
                end
            end
            VERIFICA: begin
                // A cancelled attempt is judged as a failure
                if (bus.cancel) begin
                    err_d    = 1'b1;
                    estado_d = AVALIA;
                end else if (xfer) begin
                    idx_d = idx_q + LEN_W'(1);
                    err_d = err_q | mismatch;
                    if (idx_q == len_q - LEN_W'(1)) begin
                        estado_d = AVALIA;
                    end
                end
            end
            AVALIA: begin
                if (!err_q) begin
                    tent_d   = '0;
                    estado_d = IDLE;
                end else begin
                    tent_d = tent_inc;
                    if (lock_now) begin
                        tim_d    = TIM_W'(LOCK_CYCLES - 1);
                        estado_d = BLOQUEIO;
                    end else begin
                        estado_d = IDLE;
                    end
                end
            end
            BLOQUEIO: begin
                if (tim_q == '0) begin
                    tent_d   = '0;
                    estado_d = IDLE;
                end else begin
                    tim_d = tim_q - TIM_W'(1);
                end
            end
            default: begin
                estado_d = IDLE;
            end
        endcase
    end

    // Output decode: verdict pulses come straight from the AVALIA cycle
    always_comb begin
        bus.char_ready = 1'b0;
        bus.acesso     = 1'b0;
        bus.negado     = 1'b0;
        bus.bloqueado  = 1'b0;
        bus.ocupado    = (estado_q != IDLE);
        case (estado_q)
            PROGRAMA: bus.char_ready = 1'b1;
            VERIFICA: bus.char_ready = 1'b1;
            AVALIA: begin
                bus.acesso = ~err_q;
                bus.negado = err_q & ~lock_now;
            end
            BLOQUEIO: bus.bloqueado = 1'b1;
            default: begin
            end
        endcase
    end

    assign bus.prog_ok       = prog_ok_q;
    assign bus.db_estado     = estado_q;
    assign bus.db_contagem   = idx_q;
    assign bus.db_tentativas = tent_q;

endmodule

// File: tb/tb_verificador_senha_param.sv
// Directed bench for the password engine: a table of operations with their
// expected verdicts, then hand-written lockout, saturation and reset sequences.
module tb_verificador_senha_param;
    localparam int CHAR_W = 8;
    localparam int MAX_LEN = 16;
    localparam int TENT_W = 4;
    localparam int LOCK = 8;

    typedef struct {
        string        name;
        bit           prog;
        logic [4:0]   len;
        int           n;
        logic [127:0] d;
        int           cancel_at;
        logic [3:0]   maxt;
        bit           e_acc;
        bit           e_neg;
        bit           e_pok;
        bit           e_bloq;
        logic [3:0]   e_tent;
    } vec_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   tests = 0;
    int   fails = 0;

    verificador_senha_param_if #(.CHAR_W(CHAR_W), .MAX_LEN(MAX_LEN), .TENT_W(TENT_W)) bus ();

    verificador_senha_param #(
        .CHAR_W(CHAR_W), .MAX_LEN(MAX_LEN), .TENT_W(TENT_W), .LOCK_CYCLES(LOCK)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    // Clock
    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [127:0] str2d(input string s);
        logic [127:0] r = '0;
        for (int i = 0; i < s.len(); i++) r[8*i +: 8] = s[i];
        return r;
    endfunction

    function automatic logic [127:0] seq_d(input logic [7:0] base);
        logic [127:0] r = '0;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = base + 8'(i);
        return r;
    endfunction

    function automatic vec_t mk(input string name, input bit prog, input logic [4:0] len,
                                input int n, input logic [127:0] d, input int cancel_at,
                                input logic [3:0] maxt, input bit ea, input bit en,
                                input bit ep, input bit eb, input logic [3:0] et);
        vec_t v;
        v.name = name; v.prog = prog; v.len = len; v.n = n; v.d = d;
        v.cancel_at = cancel_at; v.maxt = maxt;
        v.e_acc = ea; v.e_neg = en; v.e_pok = ep; v.e_bloq = eb; v.e_tent = et;
        return v;
    endfunction

    // Driver: one start plus n chars (or a cancel at cancel_at); samples the
    // verdict cycle, then one more cycle for lockout level and attempt count.
    task automatic do_op(input vec_t v, output bit acc, output bit neg, output bit pok,
                         output bit bloq, output logic [3:0] tent, output bit rdy_ok);
        rdy_ok = 1'b1;
        bus.max_tentativas = v.maxt;
        bus.start = 1'b1;
        bus.prog = v.prog;
        bus.senha_len = v.len;
        @(posedge clock); #1;
        bus.start = 1'b0;
        bus.prog = 1'b0;
        for (int i = 0; i < v.n; i++) begin
            if (i == v.cancel_at) begin
                bus.cancel = 1'b1;
                bus.char_valid = 1'b0;
            end else begin
                bus.char_valid = 1'b1;
                bus.char_data = v.d[8*i +: 8];
                if (!bus.char_ready) rdy_ok = 1'b0;
            end
            @(posedge clock); #1;
            if (i == v.cancel_at) begin
                bus.cancel = 1'b0;
                break;
            end
        end
        bus.char_valid = 1'b0;
        acc = bus.acesso;
        neg = bus.negado;
        pok = bus.prog_ok;
        @(posedge clock); #1;
        bloq = bus.bloqueado;
        tent = bus.db_tentativas;
    endtask

    vec_t tab[17];

    initial begin
        bit acc, neg, pok, bloq, rdy;
        logic [3:0] tent;
        logic [127:0] tmp;
        int cnt;
        bit saw_bloq;
        vec_t v;

        bus.start = 0; bus.prog = 0; bus.cancel = 0; bus.senha_len = '0;
        bus.max_tentativas = '0; bus.char_valid = 0; bus.char_data = '0;

        tmp = seq_d(8'h41);
        tmp[8*15 +: 8] = 8'h7A;
        tab[0]  = mk("rst_zero_pw",   0, 0, 16, '0,              -1, 0, 1, 0, 0, 0, 0);
        tab[1]  = mk("prog_1234",     1, 4, 4,  str2d("1234"),   -1, 0, 0, 0, 1, 0, 0);
        tab[2]  = mk("ver_1234",      0, 0, 4,  str2d("1234"),   -1, 0, 1, 0, 0, 0, 0);
        tab[3]  = mk("ver_1294",      0, 0, 4,  str2d("1294"),   -1, 0, 0, 1, 0, 0, 1);
        tab[4]  = mk("ver_1234_clr",  0, 0, 4,  str2d("1234"),   -1, 0, 1, 0, 0, 0, 0);
        tab[5]  = mk("prog_AB_cancel",1, 2, 2,  str2d("AB"),      1, 0, 0, 0, 0, 0, 0);
        tab[6]  = mk("ver_after_canc",0, 0, 4,  str2d("1234"),   -1, 0, 1, 0, 0, 0, 0);
        tab[7]  = mk("ver_cancel2",   0, 0, 4,  str2d("1234"),    2, 0, 0, 1, 0, 0, 1);
        tab[8]  = mk("prog_len0",     1, 0, 16, seq_d(8'h41),    -1, 0, 0, 0, 1, 0, 1);
        tab[9]  = mk("ver_len0",      0, 0, 16, seq_d(8'h41),    -1, 0, 1, 0, 0, 0, 0);
        tab[10] = mk("ver_len0_last", 0, 0, 16, tmp,             -1, 0, 0, 1, 0, 0, 1);
        tab[11] = mk("prog_len20",    1, 20, 16, seq_d(8'h50),   -1, 0, 0, 0, 1, 0, 1);
        tab[12] = mk("ver_len20",     0, 0, 16, seq_d(8'h50),    -1, 0, 1, 0, 0, 0, 0);
        tab[13] = mk("reprog_1234",   1, 4, 4,  str2d("1234"),   -1, 0, 0, 0, 1, 0, 0);
        tab[14] = mk("bad1_max3",     0, 0, 4,  str2d("0000"),   -1, 3, 0, 1, 0, 0, 1);
        tab[15] = mk("bad2_max3",     0, 0, 4,  str2d("0000"),   -1, 3, 0, 1, 0, 0, 2);
        tab[16] = mk("bad3_lock",     0, 0, 4,  str2d("0000"),   -1, 3, 0, 0, 0, 1, 3);

        // Reset state
        #3;
        chk("reset_outputs",
            {bus.char_ready, bus.acesso, bus.negado, bus.prog_ok, bus.bloqueado, bus.ocupado,
             bus.db_estado, bus.db_contagem, bus.db_tentativas}, '0);
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;

        // Table-driven operations
        for (int k = 0; k < 17; k++) begin
            do_op(tab[k], acc, neg, pok, bloq, tent, rdy);
            chk({tab[k].name, "_ready"},   64'(rdy),  64'(1));
            chk({tab[k].name, "_acesso"},  64'(acc),  64'(tab[k].e_acc));
            chk({tab[k].name, "_negado"},  64'(neg),  64'(tab[k].e_neg));
            chk({tab[k].name, "_prog_ok"}, 64'(pok),  64'(tab[k].e_pok));
            chk({tab[k].name, "_bloq"},    64'(bloq), 64'(tab[k].e_bloq));
            chk({tab[k].name, "_tent"},    64'(tent), 64'(tab[k].e_tent));
        end

        // Lockout duration; start pulses must be ignored while locked
        cnt = 1;
        for (int k = 0; k < 40; k++) begin
            bus.start = 1'b1;
            bus.prog = 1'b0;
            @(posedge clock); #1;
            if (bus.bloqueado) cnt++;
            else break;
        end
        bus.start = 1'b0;
        chk("lock_cycles", 64'(cnt), 64'(LOCK));
        chk("lock_exit_state", 64'(bus.db_estado), 64'(0));
        chk("lock_exit_tent", 64'(bus.db_tentativas), 64'(0));
        @(posedge clock); #1;
        chk("lock_start_ignored", 64'(bus.ocupado), 64'(0));

        // Lockout disabled: counter saturates, never locks
        saw_bloq = 1'b0;
        v = mk("sat", 0, 0, 4, str2d("0000"), -1, 0, 0, 1, 0, 0, 0);
        for (int k = 0; k < 20; k++) begin
            do_op(v, acc, neg, pok, bloq, tent, rdy);
            if (bloq) saw_bloq = 1'b1;
            chk($sformatf("sat_tent_%0d", k), 64'(tent), 64'((k + 1 > 15) ? 15 : k + 1));
        end
        chk("sat_never_locked", 64'(saw_bloq), 64'(0));

        // Reset in the middle of a verification
        bus.start = 1'b1;
        @(posedge clock); #1;
        bus.start = 1'b0;
        bus.char_valid = 1'b1;
        bus.char_data = 8'h31;
        @(posedge clock); #1;
        bus.char_data = 8'h32;
        @(posedge clock); #1;
        bus.char_valid = 1'b0;
        reset = 1'b0;
        #1;
        chk("midreset_outputs",
            {bus.char_ready, bus.acesso, bus.negado, bus.prog_ok, bus.bloqueado, bus.ocupado,
             bus.db_estado, bus.db_contagem, bus.db_tentativas}, '0);
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        v = mk("post_zero", 0, 0, 16, '0, -1, 0, 1, 0, 0, 0, 0);
        do_op(v, acc, neg, pok, bloq, tent, rdy);
        chk("postreset_zero_ready", 64'(rdy), 64'(1));
        chk("postreset_zero_acesso", 64'(acc), 64'(1));
        v = mk("post_1234", 0, 0, 16, str2d("1234"), -1, 0, 0, 1, 0, 0, 1);
        do_op(v, acc, neg, pok, bloq, tent, rdy);
        chk("postreset_1234_acesso", 64'(acc), 64'(0));
        chk("postreset_1234_negado", 64'(neg), 64'(1));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end
endmodule
